// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Trace capture unit on the CPU writeback path. Every writeback taken while
//   capturing is stored as {pc, register index, data} in a circular buffer.
//   The buffer freezes on a PC-match trigger (after POST_TRIG further
//   writebacks) or on a halt_button rising edge. Freezing raises halt_req.
//   While halted, entries drain oldest-first over a valid/ready port.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   When defined, a saturating cycle counter is added and stored with every
//   entry. The stored value is presented on rd_ts (TS_W bits).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   halt_button  manual halt level input (edge detected internally)
//   wb_en        writeback strobe
//   wb_idx       destination register index
//   wb_data      written value
//   pc           PC of the writing instruction
//   arm          pulse: clear buffer and start capture
//   trig_en      enables PC-match trigger
//   trig_pc      trigger PC
//   halt_req     high while HALTED
//   rd_valid     an entry is presented (HALTED only)
//   rd_ready     consumer accepts the entry
//   rd_pc        oldest entry PC
//   rd_idx       oldest entry register index
//   rd_data      oldest entry data
//   rd_ts        oldest entry timestamp (TRACE_TIMESTAMP_EN only)
//   count        entries held
//   overflow     sticky: an entry was overwritten since the last arm
//   state        0=IDLE 1=ARMED 2=TRIGGERED 3=HALTED

module cpu_trace_buffer #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREG      = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W      = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         halt_button,
    input  logic                         wb_en,
    input  logic [$clog2(NREG)-1:0]      wb_idx,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic [PC_W-1:0]              pc,
    input  logic                         arm,
    input  logic                         trig_en,
    input  logic [PC_W-1:0]              trig_pc,
    output logic                         halt_req,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [PC_W-1:0]              rd_pc,
    output logic [$clog2(NREG)-1:0]      rd_idx,
    output logic [DATA_W-1:0]            rd_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]              rd_ts,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [1:0]                   state
);

    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PT_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_TRIGGERED = 2'd2,
        S_HALTED    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [PT_W-1:0]    r_post;
    logic               r_hb_q;

    logic [PC_W-1:0]    r_mem_pc   [DEPTH];
    logic [IDX_W-1:0]   r_mem_idx  [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];

    logic               w_hb_rise;
    logic               w_capturing;
    logic               w_cap;
    logic               w_pop;
    logic               w_match;
    logic               w_full;

    assign w_hb_rise   = halt_button & ~r_hb_q;
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_TRIGGERED);
    // arm drops any coincident writeback or read handshake
    assign w_cap       = wb_en & w_capturing & ~arm;
    assign w_pop       = (r_state == S_HALTED) & (r_count != '0) & rd_ready & ~arm;
    assign w_match     = trig_en & wb_en & (pc == trig_pc);
    assign w_full      = (r_count == CNT_W'(DEPTH));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (arm) begin
            w_next_state = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (w_hb_rise) begin
                        w_next_state = S_HALTED;
                    end else if (w_match) begin
                        w_next_state = (POST_TRIG == 0) ? S_HALTED : S_TRIGGERED;
                    end
                end
                S_TRIGGERED: begin
                    // the capture that drains the post counter to zero freezes
                    if (w_hb_rise || (wb_en && (r_post == PT_W'(1)))) begin
                        w_next_state = S_HALTED;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Output logic
    always_comb begin
        state    = r_state;
        halt_req = (r_state == S_HALTED);
        rd_valid = (r_state == S_HALTED) && (r_count != '0);
        count    = r_count;
        overflow = r_overflow;
        rd_pc    = r_mem_pc[r_rptr];
        rd_idx   = r_mem_idx[r_rptr];
        rd_data  = r_mem_data[r_rptr];
    end

    // Pointers, occupancy, overflow, post-trigger counter, halt edge register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_post     <= '0;
            r_hb_q     <= 1'b0;
        end else begin
            r_hb_q <= halt_button;
            if (arm) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_cap) begin
                    r_wptr <= r_wptr + AW'(1);
                    if (w_full) begin
                        // oldest entry is overwritten; read side follows
                        r_rptr     <= r_rptr + AW'(1);
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end else if (w_pop) begin
                    r_rptr  <= r_rptr + AW'(1);
                    r_count <= r_count - CNT_W'(1);
                end
                if ((r_state == S_ARMED) && w_match) begin
                    r_post <= PT_W'(POST_TRIG);
                end else if ((r_state == S_TRIGGERED) && wb_en && (r_post != '0)) begin
                    r_post <= r_post - PT_W'(1);
                end
            end
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem_pc[r_wptr]   <= pc;
            r_mem_idx[r_wptr]  <= wb_idx;
            r_mem_data[r_wptr] <= wb_data;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_ts [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else if (arm) begin
            r_ts <= '0;
        end else if (w_capturing && (r_ts != '1)) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem_ts[r_wptr] <= r_ts;
        end
    end

    assign rd_ts = r_mem_ts[r_rptr];
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 5;

    logic              clk;
    logic              rst;
    logic              halt_button;
    logic              wb_en;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic [PC_W-1:0]   pc;
    logic              arm;
    logic              trig_en;
    logic [PC_W-1:0]   trig_pc;
    logic              halt_req;
    logic              rd_valid;
    logic              rd_ready;
    logic [PC_W-1:0]   rd_pc;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]       rd_ts;
`endif
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [1:0]        state;

    int n_tests;
    int n_fail;

    cpu_trace_buffer #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .NREG      (8),
        .DEPTH     (16),
        .POST_TRIG (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_button (halt_button),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .pc          (pc),
        .arm         (arm),
        .trig_en     (trig_en),
        .trig_pc     (trig_pc),
        .halt_req    (halt_req),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_pc       (rd_pc),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts       (rd_ts),
`endif
        .count       (count),
        .overflow    (overflow),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: called at a negedge, return at a negedge.
    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_wb(input logic [PC_W-1:0] p, input logic [IDX_W-1:0] i,
                         input logic [DATA_W-1:0] d);
        wb_en   = 1'b1;
        pc      = p;
        wb_idx  = i;
        wb_data = d;
        @(negedge clk);
        wb_en   = 1'b0;
    endtask

    task automatic press_halt();
        halt_button = 1'b1;
        @(negedge clk);
        halt_button = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++;
        if (rd_valid !== 1'b0 || halt_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs: rd_valid=%b halt_req=%b expected 0 0", rd_valid, halt_req);
        end
        // reset in the middle of a capture, without a clock edge
        do_arm();
        for (int k = 0; k < 5; k++) do_wb(32'h200 + 32'(k * 4), 3'(k), 32'(k));
        n_tests++;
        if (state !== 2'd1 || count !== 5'd5) begin
            n_fail++; $display("FAIL midcap_pre: state=%0d count=%0d expected 1 5", state, count);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (state !== 2'd0 || count !== 5'd0 || overflow !== 1'b0 || halt_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d count=%0d ovf=%b halt=%b expected 0 0 0 0",
                     state, count, overflow, halt_req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_readout();
        logic [PC_W-1:0]   exp_pc   [3];
        logic [IDX_W-1:0]  exp_idx  [3];
        logic [DATA_W-1:0] exp_data [3];
        exp_pc   = '{32'h10, 32'h14, 32'h18};
        exp_idx  = '{3'd1, 3'd2, 3'd3};
        exp_data = '{32'd7, 32'd8, 32'd9};
        do_arm();
        for (int k = 0; k < 3; k++) do_wb(exp_pc[k], exp_idx[k], exp_data[k]);
        press_halt();
        n_tests++;
        if (state !== 2'd3 || halt_req !== 1'b1) begin
            n_fail++; $display("FAIL basic_halt: state=%0d halt_req=%b expected 3 1", state, halt_req);
        end
        n_tests++;
        if (count !== 5'd3 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_count: count=%0d rd_valid=%b expected 3 1", count, rd_valid);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (rd_pc !== exp_pc[k] || rd_idx !== exp_idx[k] || rd_data !== exp_data[k]) begin
                n_fail++;
                $display("FAIL basic_entry%0d: got (%h,%0d,%0d) expected (%h,%0d,%0d)", k,
                         rd_pc, rd_idx, rd_data, exp_pc[k], exp_idx[k], exp_data[k]);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        n_tests++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL basic_drained: count=%0d rd_valid=%b state=%0d expected 0 0 3",
                     count, rd_valid, state);
        end
    endtask

    task automatic test_overflow();
        do_arm();
        for (int k = 1; k <= 20; k++) do_wb(32'h100 + 32'(k * 4), 3'(k % 8), 32'(k));
        press_halt();
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_status: count=%0d overflow=%b expected 16 1", count, overflow);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (rd_data !== 32'(k + 5) || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_read%0d: data=%0d valid=%b expected %0d 1", k, rd_data, rd_valid, k + 5);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++; $display("FAIL ovf_drained: rd_valid=%b count=%0d expected 0 0", rd_valid, count);
        end
    endtask

    task automatic test_pc_trigger();
        logic [DATA_W-1:0] exp_data [7];
        exp_data = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        trig_en = 1'b1;
        trig_pc = 32'h40;
        do_arm();
        do_wb(32'h30, 3'd1, 32'hA0);
        do_wb(32'h34, 3'd2, 32'hA1);
        n_tests++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL trig_nomatch: state=%0d expected 1", state); end
        do_wb(32'h40, 3'd3, 32'hB0);
        n_tests++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL trig_fire: state=%0d expected 2", state); end
        for (int k = 1; k <= 6; k++) begin
            do_wb(32'h40 + 32'(k * 4), 3'(k), 32'hB0 + 32'(k));
            if (k == 3) begin
                n_tests++;
                if (state !== 2'd2) begin n_fail++; $display("FAIL trig_post3: state=%0d expected 2", state); end
            end
            if (k == 4) begin
                n_tests++;
                if (state !== 2'd3) begin n_fail++; $display("FAIL trig_post4: state=%0d expected 3", state); end
            end
        end
        n_tests++;
        if (count !== 5'd7) begin n_fail++; $display("FAIL trig_count: count=%0d expected 7", count); end
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (rd_data !== exp_data[k]) begin
                n_fail++; $display("FAIL trig_entry%0d: data=%h expected %h", k, rd_data, exp_data[k]);
            end
            if (k == 2) begin
                n_tests++;
                if (rd_pc !== 32'h40) begin n_fail++; $display("FAIL trig_pc: pc=%h expected 40", rd_pc); end
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL trig_drained: rd_valid=%b expected 0", rd_valid); end
    endtask

    task automatic test_arm_priority();
        // arm coincides with a matching writeback: only the arm takes effect
        arm     = 1'b1;
        wb_en   = 1'b1;
        pc      = 32'h40;
        wb_idx  = 3'd5;
        wb_data = 32'hCC;
        @(negedge clk);
        arm   = 1'b0;
        wb_en = 1'b0;
        n_tests++;
        if (state !== 2'd1 || count !== 5'd0) begin
            n_fail++; $display("FAIL arm_prio: state=%0d count=%0d expected 1 0", state, count);
        end
        rd_ready = 1'b1;
        do_wb(32'h50, 3'd1, 32'h1);
        n_tests++;
        if (state !== 2'd1 || count !== 5'd1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL armed_ready_ignored: state=%0d count=%0d valid=%b expected 1 1 0",
                     state, count, rd_valid);
        end
        rd_ready = 1'b0;
        do_wb(32'h40, 3'd2, 32'h2);
        n_tests++;
        if (state !== 2'd2 || count !== 5'd2) begin
            n_fail++; $display("FAIL arm_then_trig: state=%0d count=%0d expected 2 2", state, count);
        end
        trig_en = 1'b0;
    endtask

    task automatic test_ready_toggle();
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] ts_prev;
`endif
        do_arm();
        do_wb(32'h60, 3'd1, 32'h11);
        do_wb(32'h64, 3'd2, 32'h22);
        do_wb(32'h68, 3'd3, 32'h33);
        press_halt();
        rd_ready = 1'b1;
        n_tests++;
        if (rd_data !== 32'h11 || count !== 5'd3) begin
            n_fail++; $display("FAIL tog_first: data=%h count=%0d expected 11 3", rd_data, count);
        end
`ifdef TRACE_TIMESTAMP_EN
        ts_prev = rd_ts;
`endif
        @(negedge clk);
        rd_ready = 1'b0;
        n_tests++;
        if (rd_data !== 32'h22 || count !== 5'd2) begin
            n_fail++; $display("FAIL tog_pop1: data=%h count=%0d expected 22 2", rd_data, count);
        end
`ifdef TRACE_TIMESTAMP_EN
        n_tests++;
        if (rd_ts <= ts_prev) begin n_fail++; $display("FAIL ts_inc1: ts=%0d prev=%0d expected greater", rd_ts, ts_prev); end
        ts_prev = rd_ts;
`endif
        @(negedge clk);
        n_tests++;
        if (rd_data !== 32'h22 || count !== 5'd2 || rd_pc !== 32'h64 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tog_hold: data=%h count=%0d pc=%h valid=%b expected 22 2 64 1",
                     rd_data, count, rd_pc, rd_valid);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        n_tests++;
        if (rd_data !== 32'h33 || count !== 5'd1) begin
            n_fail++; $display("FAIL tog_pop2: data=%h count=%0d expected 33 1", rd_data, count);
        end
`ifdef TRACE_TIMESTAMP_EN
        n_tests++;
        if (rd_ts <= ts_prev) begin n_fail++; $display("FAIL ts_inc2: ts=%0d prev=%0d expected greater", rd_ts, ts_prev); end
`endif
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        halt_button = 1'b0;
        wb_en       = 1'b0;
        wb_idx      = '0;
        wb_data     = '0;
        pc          = '0;
        arm         = 1'b0;
        trig_en     = 1'b0;
        trig_pc     = '0;
        rd_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic_readout();
        test_overflow();
        test_pc_trigger();
        test_arm_priority();
        test_ready_toggle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
